// File: rtl/pr_shutdown_pkg.sv
// Shared types and helpers for the PR region shutdown sequencer.
// State names follow the region's lifecycle: running, draining, isolated, releasing, settling.
package pr_shutdown_pkg;

  typedef enum logic [2:0] {
    ACTIVE,
    DRAIN,
    SHUTDOWN,
    RELEASE,
    SETTLE
  } state_t;

  localparam int PR_MAX_CHANNELS = 32;

  // Bits needed to hold the larger of two cycle limits without wrapping.
  function automatic int clog2_max(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pr_shutdown_timer.sv
// Saturating up-counter with synchronous clear and a terminal-count compare.
// The count stops at all-ones so a long wait can never alias back to a small value.
module pr_shutdown_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] term,
  output logic         hit
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + W'(1);
    end
  end

  assign hit = (count == term);

endmodule

// File: rtl/pr_shutdown_sequencer.sv
// Sequences shutdown/release of N AXIS decouplers around a PR region and reports
// isolated/active status with bounded ack waits and sticky timeout diagnostics.
module pr_shutdown_sequencer
  import pr_shutdown_pkg::*;
#(
  parameter int C_NUM_CHANNELS   = 4,
  parameter int C_TIMEOUT_CYCLES = 65535,
  parameter int C_SETTLE_CYCLES  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_shutdown,
  input  logic                      clr_timeout,
  output logic [C_NUM_CHANNELS-1:0] shutdown_req,
  input  logic [C_NUM_CHANNELS-1:0] shutdown_ack,
  output logic                      status_shutdown,
  output logic                      status_active,
  output logic                      status_timeout,
  output logic [C_NUM_CHANNELS-1:0] timeout_ch
);

  localparam int CW = clog2_max(C_TIMEOUT_CYCLES, C_SETTLE_CYCLES);
  localparam bit TIMEOUT_EN = (C_TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] TIMEOUT_TERM =
    TIMEOUT_EN ? CW'(C_TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CW-1:0] SETTLE_TERM = CW'(C_SETTLE_CYCLES - 1);

  state_t                    state;
  state_t                    state_nxt;
  logic                      tmr_clear;
  logic                      tmr_en;
  logic                      tmr_hit;
  logic [CW-1:0]             tmr_term;
  logic                      to_fire;
  logic [C_NUM_CHANNELS-1:0] to_mask;

  assign tmr_term = (state == SETTLE) ? SETTLE_TERM : TIMEOUT_TERM;

  pr_shutdown_timer #(
    .W(CW)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tmr_clear),
    .enable (tmr_en),
    .term   (tmr_term),
    .hit    (tmr_hit)
  );

  // Every transition restarts the wait counter; only waiting states let it run.
  always_comb begin
    state_nxt = state;
    tmr_clear = 1'b0;
    tmr_en    = 1'b0;
    to_fire   = 1'b0;
    to_mask   = '0;
    case (state)
      ACTIVE: begin
        tmr_clear = 1'b1;
        if (req_shutdown) state_nxt = DRAIN;
      end
      DRAIN: begin
        tmr_en = 1'b1;
        if (&shutdown_ack) begin
          state_nxt = SHUTDOWN;
          tmr_clear = 1'b1;
        end else if (!req_shutdown) begin
          state_nxt = RELEASE;
          tmr_clear = 1'b1;
        end else if (TIMEOUT_EN && tmr_hit) begin
          to_fire   = 1'b1;
          to_mask   = ~shutdown_ack;
          state_nxt = SHUTDOWN;
          tmr_clear = 1'b1;
        end
      end
      SHUTDOWN: begin
        tmr_clear = 1'b1;
        if (!req_shutdown) state_nxt = RELEASE;
      end
      RELEASE: begin
        tmr_en = 1'b1;
        if (!(|shutdown_ack)) begin
          state_nxt = SETTLE;
          tmr_clear = 1'b1;
        end else if (TIMEOUT_EN && tmr_hit) begin
          to_fire   = 1'b1;
          to_mask   = shutdown_ack;
          state_nxt = SETTLE;
          tmr_clear = 1'b1;
        end
      end
      SETTLE: begin
        tmr_en = 1'b1;
        if (req_shutdown) begin
          state_nxt = DRAIN;
          tmr_clear = 1'b1;
        end else if (tmr_hit) begin
          state_nxt = ACTIVE;
          tmr_clear = 1'b1;
        end
      end
      default: begin
        state_nxt = SETTLE;
        tmr_clear = 1'b1;
      end
    endcase
  end

  // Outputs decode the current state, so they trail each state change by one edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= SETTLE;
      shutdown_req    <= '0;
      status_shutdown <= 1'b0;
      status_active   <= 1'b0;
      status_timeout  <= 1'b0;
      timeout_ch      <= '0;
    end else begin
      state           <= state_nxt;
      shutdown_req    <= {C_NUM_CHANNELS{(state == DRAIN) || (state == SHUTDOWN)}};
      status_shutdown <= (state == SHUTDOWN);
      status_active   <= (state == ACTIVE);
      if (to_fire) begin
        status_timeout <= 1'b1;
        timeout_ch     <= timeout_ch | to_mask;
      end else if (clr_timeout) begin
        status_timeout <= 1'b0;
        timeout_ch     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pr_shutdown_sequencer.sv
// Self-checking bench for pr_shutdown_sequencer: directed lifecycle scenarios then
// randomized decoupler behaviour, all compared against a cycle-level behavioural model.
module tb_pr_shutdown_sequencer;

  localparam int N   = 4;
  localparam int TMO = 8;
  localparam int STL = 16;

  localparam int PH_RUN   = 100;
  localparam int PH_DRAIN = 101;
  localparam int PH_ISO   = 102;
  localparam int PH_REL   = 103;
  localparam int PH_STL   = 104;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_shutdown = 1'b0;
  logic         clr_timeout = 1'b0;
  logic [N-1:0] shutdown_req;
  logic [N-1:0] shutdown_ack = '0;
  logic         status_shutdown;
  logic         status_active;
  logic         status_timeout;
  logic [N-1:0] timeout_ch;

  int checks = 0;
  int errors = 0;

  int           phase = PH_STL;
  int           waited = 0;
  logic [N-1:0] exp_req = '0;
  logic         exp_sd = 1'b0;
  logic         exp_act = 1'b0;
  logic         exp_to = 1'b0;
  logic [N-1:0] exp_ch = '0;

  pr_shutdown_sequencer #(
    .C_NUM_CHANNELS   (N),
    .C_TIMEOUT_CYCLES (TMO),
    .C_SETTLE_CYCLES  (STL)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_shutdown    (req_shutdown),
    .clr_timeout     (clr_timeout),
    .shutdown_req    (shutdown_req),
    .shutdown_ack    (shutdown_ack),
    .status_shutdown (status_shutdown),
    .status_active   (status_active),
    .status_timeout  (status_timeout),
    .timeout_ch      (timeout_ch)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, actual, expected);
    end
  endtask

  // Behavioural model: registered outputs reflect the phase held before this edge.
  task automatic modelStep();
    int   nxt;
    logic fire;
    logic [N-1:0] mask;
    if (!rst_n) begin
      phase = PH_STL; waited = 0;
      exp_req = '0; exp_sd = 0; exp_act = 0; exp_to = 0; exp_ch = '0;
      return;
    end
    exp_req = (phase == PH_DRAIN || phase == PH_ISO) ? {N{1'b1}} : '0;
    exp_sd  = (phase == PH_ISO);
    exp_act = (phase == PH_RUN);
    nxt = phase; fire = 0; mask = '0;
    case (phase)
      PH_RUN:   if (req_shutdown) nxt = PH_DRAIN;
      PH_DRAIN: begin
        if (shutdown_ack == {N{1'b1}}) nxt = PH_ISO;
        else if (!req_shutdown) nxt = PH_REL;
        else if (waited == TMO - 1) begin fire = 1; mask = ~shutdown_ack; nxt = PH_ISO; end
      end
      PH_ISO:   if (!req_shutdown) nxt = PH_REL;
      PH_REL: begin
        if (shutdown_ack == '0) nxt = PH_STL;
        else if (waited == TMO - 1) begin fire = 1; mask = shutdown_ack; nxt = PH_STL; end
      end
      default: begin
        if (req_shutdown) nxt = PH_DRAIN;
        else if (waited == STL - 1) nxt = PH_RUN;
      end
    endcase
    if (fire) begin exp_to = 1; exp_ch = exp_ch | mask; end
    else if (clr_timeout) begin exp_to = 0; exp_ch = '0; end
    waited = (nxt != phase) ? 0 : waited + 1;
    phase = nxt;
  endtask

  task automatic compareAll();
    checkOutput("shutdown_req", 32'(shutdown_req), 32'(exp_req));
    checkOutput("status_shutdown", 32'(status_shutdown), 32'(exp_sd));
    checkOutput("status_active", 32'(status_active), 32'(exp_act));
    checkOutput("status_timeout", 32'(status_timeout), 32'(exp_to));
    checkOutput("timeout_ch", 32'(timeout_ch), 32'(exp_ch));
  endtask

  task automatic applyStimulus(input logic r, input logic [N-1:0] a, input logic c, input logic rn);
    req_shutdown = r; shutdown_ack = a; clr_timeout = c; rst_n = rn;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    compareAll();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [N-1:0] ack_v;
    int lazy_ch;

    @(negedge clk);
    // Reset state and settle-to-active after reset
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("reset_req", 32'(shutdown_req), 32'h0);
    checkOutput("reset_active", 32'(status_active), 32'h0);
    idleCycles(16);
    checkOutput("settle_not_yet_active", 32'(status_active), 32'h0);
    idleCycles(1);
    checkOutput("settle_active", 32'(status_active), 32'h1);

    // Normal shutdown: acks answer three cycles after the request
    applyStimulus(1'b1, '0, 1'b0, 1'b1);
    checkOutput("drain_req_lag", 32'(shutdown_req), 32'h0);
    applyStimulus(1'b1, '0, 1'b0, 1'b1);
    checkOutput("drain_req_high", 32'(shutdown_req), 32'hF);
    applyStimulus(1'b1, '0, 1'b0, 1'b1);
    applyStimulus(1'b1, 4'hF, 1'b0, 1'b1);
    checkOutput("iso_lag", 32'(status_shutdown), 32'h0);
    applyStimulus(1'b1, 4'hF, 1'b0, 1'b1);
    checkOutput("iso_high", 32'(status_shutdown), 32'h1);
    checkOutput("iso_no_timeout", 32'(status_timeout), 32'h0);
    applyStimulus(1'b0, 4'hF, 1'b0, 1'b1);
    idleCycles(20);

    // Drain timeout with channel 2 stuck low
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 4'b1011, 1'b0, 1'b1);
    checkOutput("drain_to_before", 32'(status_timeout), 32'h0);
    applyStimulus(1'b1, 4'b1011, 1'b0, 1'b1);
    checkOutput("drain_to_flag", 32'(status_timeout), 32'h1);
    checkOutput("drain_to_ch", 32'(timeout_ch), 32'h4);
    applyStimulus(1'b1, 4'b1011, 1'b0, 1'b1);
    checkOutput("forced_iso", 32'(status_shutdown), 32'h1);

    // Release timeout coinciding with clr_timeout: the set must win
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 4'b0001, 1'b0, 1'b1);
    applyStimulus(1'b0, 4'b0001, 1'b1, 1'b1);
    checkOutput("clr_vs_set", 32'(status_timeout), 32'h1);
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    checkOutput("clr_flag", 32'(status_timeout), 32'h0);
    checkOutput("clr_ch", 32'(timeout_ch), 32'h0);
    idleCycles(20);

    // Abort from DRAIN with partial acks, then release
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'b0011, 1'b0, 1'b1);
    applyStimulus(1'b0, 4'b0011, 1'b0, 1'b1);
    applyStimulus(1'b0, 4'b0011, 1'b0, 1'b1);
    checkOutput("abort_req_low", 32'(shutdown_req), 32'h0);
    applyStimulus(1'b0, 4'b0011, 1'b0, 1'b1);
    idleCycles(17);
    checkOutput("abort_not_yet_active", 32'(status_active), 32'h0);
    idleCycles(1);
    checkOutput("abort_active", 32'(status_active), 32'h1);

    // Request during SETTLE goes straight back to DRAIN
    applyStimulus(1'b1, 4'hF, 1'b0, 1'b1);
    applyStimulus(1'b1, 4'hF, 1'b0, 1'b1);
    applyStimulus(1'b0, 4'hF, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    idleCycles(5);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, '0, 1'b0, 1'b1);
      checkOutput("settle_abort_no_active", 32'(status_active), 32'h0);
    end

    // Reset while isolated
    applyStimulus(1'b1, 4'hF, 1'b0, 1'b1);
    applyStimulus(1'b1, 4'hF, 1'b0, 1'b1);
    applyStimulus(1'b1, 4'hF, 1'b0, 0);
    checkOutput("rst_iso_req", 32'(shutdown_req), 32'h0);
    checkOutput("rst_iso_sd", 32'(status_shutdown), 32'h0);
    idleCycles(16);
    checkOutput("rst_iso_not_active", 32'(status_active), 32'h0);
    idleCycles(1);
    checkOutput("rst_iso_active", 32'(status_active), 32'h1);

    // Randomized decouplers: responsive most of the time, one lazy channel in some windows
    ack_v = '0;
    lazy_ch = -1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic r;
      if (cyc % 200 == 0) lazy_ch = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N - 1)) : -1;
      if ($urandom_range(0, 39) == 0) r = ~req_shutdown; else r = req_shutdown;
      for (int ch = 0; ch < N; ch++) begin
        if (ch == lazy_ch) begin
          if ($urandom_range(0, 39) == 0) ack_v[ch] = exp_req[ch];
        end else if ($urandom_range(0, 2) == 0) begin
          ack_v[ch] = exp_req[ch];
        end
      end
      applyStimulus(r, ack_v, ($urandom_range(0, 29) == 0), ($urandom_range(0, 499) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
